// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: data width,
// funct3 access encodings, FSM states and the EX/M register bundle.
package rv32i_pkg;

    localparam int DPW = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    typedef struct packed {
        logic           regwrite;
        logic           resultsrc;
        logic           memwrite;
        logic           memread;
        logic [2:0]     funct3;
        logic [DPW-1:0] alu;
        logic [DPW-1:0] wdata;
        logic [4:0]     rd;
    } ex_m_t;

    function automatic logic misaligned(input logic [2:0] f3,
                                        input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage
// (master) and the data memory (slave).
interface memory_stage_if;

    logic                         dmem_req_o;
    logic                         dmem_we_o;
    logic [rv32i_pkg::DPW-1:0]    dmem_addr_o;
    logic [rv32i_pkg::DPW-1:0]    dmem_wdata_o;
    logic [3:0]                   dmem_be_o;
    logic                         dmem_ready_i;
    logic [rv32i_pkg::DPW-1:0]    dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o,
        output dmem_wdata_o, dmem_be_o,
        input  dmem_ready_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o,
        input  dmem_wdata_o, dmem_be_o,
        output dmem_ready_i, dmem_rdata_i
    );

endinterface

// File: rtl/load_align.sv
// Combinational load lane select plus sign/zero extension.
module load_align
    import rv32i_pkg::*;
(
    input  logic           i_memread,
    input  logic [2:0]     i_funct3,
    input  logic [1:0]     i_off,
    input  logic [DPW-1:0] i_rdata,
    output logic [DPW-1:0] o_data
);

    logic [DPW-1:0] w_shift;
    logic [7:0]     w_b;
    logic [15:0]    w_h;

    assign w_shift = i_rdata >> {i_off, 3'b000};
    assign w_b     = w_shift[7:0];
    assign w_h     = w_shift[15:0];

    always_comb begin
        o_data = '0;
        if (i_memread) begin
            case (i_funct3)
                F3_B:    o_data = {{(DPW-8){w_b[7]}}, w_b};
                F3_H:    o_data = {{(DPW-16){w_h[15]}}, w_h};
                F3_W:    o_data = i_rdata;
                F3_BU:   o_data = {{(DPW-8){1'b0}}, w_b};
                F3_HU:   o_data = {{(DPW-16){1'b0}}, w_h};
                default: o_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory stage: EX/M register, data-memory handshake FSM,
// store lane steering and load alignment.
module memory_stage
    import rv32i_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           regwriteE,
    input  logic           resultsrcE,
    input  logic           memwriteE,
    input  logic           memreadE,
    input  logic [2:0]     funct3E,
    input  logic [DPW-1:0] aluresultE,
    input  logic [DPW-1:0] writedataE,
    input  logic [4:0]     RdE,
    input  logic           flushE,
    memory_stage_if.master dmem,
    output logic           regwriteM,
    output logic           resultsrcM,
    output logic [DPW-1:0] aluresultM,
    output logic [DPW-1:0] ReadDataM,
    output logic [4:0]     RdM,
    output logic           stallM,
    output logic           misalignM
);

    ex_m_t      r_ex;
    ex_m_t      w_next;
    logic [0:0] r_state;
    logic       w_memop;
    logic       w_mis;
    logic       w_req;
    logic [1:0] w_off;

    always_comb begin
        w_next           = '0;
        w_next.regwrite  = regwriteE;
        w_next.resultsrc = resultsrcE;
        w_next.memwrite  = memwriteE;
        w_next.memread   = memreadE;
        w_next.funct3    = funct3E;
        w_next.alu       = aluresultE;
        w_next.wdata     = writedataE;
        w_next.rd        = RdE;
    end

    assign w_off   = r_ex.alu[1:0];
    assign w_memop = r_ex.memread | r_ex.memwrite;
    assign w_mis   = w_memop & misaligned(r_ex.funct3, w_off);
    // A request in WAIT is held regardless of inputs until ready.
    assign w_req   = (r_state == ST_WAIT) | (w_memop & ~w_mis);
    assign stallM  = w_req & ~dmem.dmem_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (!stallM) begin
            r_ex <= flushE ? '0 : w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_req && !dmem.dmem_ready_i) r_state <= ST_WAIT;
                ST_WAIT: if (dmem.dmem_ready_i)           r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req_o  = w_req;
    assign dmem.dmem_we_o   = r_ex.memwrite;
    assign dmem.dmem_addr_o = {r_ex.alu[DPW-1:2], 2'b00};

    always_comb begin
        case (r_ex.funct3[1:0])
            2'b00: begin
                dmem.dmem_be_o    = 4'b0001 << w_off;
                dmem.dmem_wdata_o = {4{r_ex.wdata[7:0]}};
            end
            2'b01: begin
                dmem.dmem_be_o    = 4'b0011 << w_off;
                dmem.dmem_wdata_o = {2{r_ex.wdata[15:0]}};
            end
            default: begin
                dmem.dmem_be_o    = 4'b1111;
                dmem.dmem_wdata_o = r_ex.wdata;
            end
        endcase
    end

    load_align u_load_align (
        .i_memread (r_ex.memread),
        .i_funct3  (r_ex.funct3),
        .i_off     (w_off),
        .i_rdata   (dmem.dmem_rdata_i),
        .o_data    (ReadDataM)
    );

    assign regwriteM  = r_ex.regwrite & ~stallM & ~w_mis;
    assign resultsrcM = r_ex.resultsrc;
    assign aluresultM = r_ex.alu;
    assign RdM        = r_ex.rd;
    assign misalignM  = w_mis;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;
    import rv32i_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           regwriteE, resultsrcE, memwriteE, memreadE, flushE;
    logic [2:0]     funct3E;
    logic [DPW-1:0] aluresultE, writedataE;
    logic [4:0]     RdE;
    logic           regwriteM, resultsrcM, stallM, misalignM;
    logic [DPW-1:0] aluresultM, ReadDataM;
    logic [4:0]     RdM;

    int errors = 0;
    int checks = 0;

    memory_stage_if dmem ();

    memory_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .regwriteE  (regwriteE),
        .resultsrcE (resultsrcE),
        .memwriteE  (memwriteE),
        .memreadE   (memreadE),
        .funct3E    (funct3E),
        .aluresultE (aluresultE),
        .writedataE (writedataE),
        .RdE        (RdE),
        .flushE     (flushE),
        .dmem       (dmem.master),
        .regwriteM  (regwriteM),
        .resultsrcM (resultsrcM),
        .aluresultM (aluresultM),
        .ReadDataM  (ReadDataM),
        .RdM        (RdM),
        .stallM     (stallM),
        .misalignM  (misalignM)
    );

    always #5 clk = ~clk;

    task automatic set_e(input logic rw, input logic rs, input logic mw,
                         input logic mr, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd);
        regwriteE  = rw;
        resultsrcE = rs;
        memwriteE  = mw;
        memreadE   = mr;
        funct3E    = f3;
        aluresultE = alu;
        writedataE = wd;
        RdE        = rd;
    endtask

    task automatic bubble_e();
        set_e(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flushE = 1'b0;
        bubble_e();
        dmem.dmem_ready_i = 1'b0;
        dmem.dmem_rdata_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (dmem.dmem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", dmem.dmem_req_o); end
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stallM); end
        checks++; if (misalignM !== 1'b0) begin errors++; $display("FAIL rst_mis got %b want 0", misalignM); end
        checks++; if (regwriteM !== 1'b0) begin errors++; $display("FAIL rst_rw got %b want 0", regwriteM); end
        checks++; if (aluresultM !== 32'h0) begin errors++; $display("FAIL rst_alu got %h want 0", aluresultM); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_lw_zero_wait();
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_W, 32'h100, 32'h0, 5'd3);
        dmem.dmem_ready_i = 1'b1;
        dmem.dmem_rdata_i = 32'hDEADBEEF;
        step();
        bubble_e();
        @(negedge clk);
        checks++; if (ReadDataM !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", ReadDataM); end
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL lw_stall got %b want 0", stallM); end
        checks++; if (dmem.dmem_req_o !== 1'b1) begin errors++; $display("FAIL lw_req got %b want 1", dmem.dmem_req_o); end
        checks++; if (dmem.dmem_addr_o !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", dmem.dmem_addr_o); end
        checks++; if (regwriteM !== 1'b1 || RdM !== 5'd3) begin errors++; $display("FAIL lw_wb got rw=%b rd=%0d want 1,3", regwriteM, RdM); end
        step();
        @(negedge clk);
        checks++; if (dmem.dmem_req_o !== 1'b0) begin errors++; $display("FAIL bubble_req got %b want 0", dmem.dmem_req_o); end
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL bubble_data got %h want 0", ReadDataM); end
    endtask

    task automatic test_back_to_back();
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_B, 32'h103, 32'h0, 5'd4);
        dmem.dmem_ready_i = 1'b1;
        dmem.dmem_rdata_i = 32'h80FF1234;
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_BU, 32'h103, 32'h0, 5'd5);
        @(negedge clk);
        checks++; if (ReadDataM !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", ReadDataM); end
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_H, 32'h102, 32'h0, 5'd6);
        @(negedge clk);
        checks++; if (ReadDataM !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h want 00000080", ReadDataM); end
        checks++; if (RdM !== 5'd5) begin errors++; $display("FAIL lbu_rd got %0d want 5", RdM); end
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_HU, 32'h100, 32'h0, 5'd7);
        @(negedge clk);
        checks++; if (ReadDataM !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_data got %h want ffff80ff", ReadDataM); end
        step();
        bubble_e();
        @(negedge clk);
        checks++; if (ReadDataM !== 32'h00001234) begin errors++; $display("FAIL lhu_data got %h want 00001234", ReadDataM); end
    endtask

    task automatic test_store();
        step();
        set_e(1'b0, 1'b0, 1'b1, 1'b0, F3_H, 32'h202, 32'h0000ABCD, 5'd0);
        dmem.dmem_ready_i = 1'b1;
        step();
        set_e(1'b0, 1'b0, 1'b1, 1'b0, F3_B, 32'h201, 32'h00000012, 5'd0);
        @(negedge clk);
        checks++; if (dmem.dmem_be_o !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", dmem.dmem_be_o); end
        checks++; if (dmem.dmem_wdata_o !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", dmem.dmem_wdata_o); end
        checks++; if (dmem.dmem_addr_o !== 32'h200) begin errors++; $display("FAIL sh_addr got %h want 200", dmem.dmem_addr_o); end
        checks++; if (dmem.dmem_we_o !== 1'b1 || dmem.dmem_req_o !== 1'b1) begin errors++; $display("FAIL sh_we_req got we=%b req=%b want 1,1", dmem.dmem_we_o, dmem.dmem_req_o); end
        step();
        bubble_e();
        @(negedge clk);
        checks++; if (dmem.dmem_be_o !== 4'b0010) begin errors++; $display("FAIL sb_be got %b want 0010", dmem.dmem_be_o); end
        checks++; if (dmem.dmem_wdata_o !== 32'h12121212) begin errors++; $display("FAIL sb_wdata got %h want 12121212", dmem.dmem_wdata_o); end
        checks++; if (regwriteM !== 1'b0) begin errors++; $display("FAIL sb_rw got %b want 0", regwriteM); end
    endtask

    task automatic test_wait();
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_W, 32'h104, 32'h0, 5'd5);
        dmem.dmem_ready_i = 1'b0;
        dmem.dmem_rdata_i = 32'h0;
        step();
        set_e(1'b1, 1'b0, 1'b0, 1'b0, F3_W, 32'h55, 32'h0, 5'd6);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL wait_stall%0d got %b want 1", c, stallM); end
            checks++; if (regwriteM !== 1'b0) begin errors++; $display("FAIL wait_rw%0d got %b want 0", c, regwriteM); end
            checks++; if (dmem.dmem_req_o !== 1'b1 || dmem.dmem_addr_o !== 32'h104) begin errors++; $display("FAIL wait_hold%0d got req=%b addr=%h want 1,104", c, dmem.dmem_req_o, dmem.dmem_addr_o); end
            step();
        end
        dmem.dmem_ready_i = 1'b1;
        dmem.dmem_rdata_i = 32'hCAFEF00D;
        @(negedge clk);
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL done_stall got %b want 0", stallM); end
        checks++; if (regwriteM !== 1'b1 || RdM !== 5'd5) begin errors++; $display("FAIL done_wb got rw=%b rd=%0d want 1,5", regwriteM, RdM); end
        checks++; if (ReadDataM !== 32'hCAFEF00D) begin errors++; $display("FAIL done_data got %h want cafef00d", ReadDataM); end
        step();
        dmem.dmem_ready_i = 1'b0;
        bubble_e();
        @(negedge clk);
        checks++; if (aluresultM !== 32'h55 || RdM !== 5'd6 || regwriteM !== 1'b1) begin errors++; $display("FAIL next_instr got alu=%h rd=%0d rw=%b want 55,6,1", aluresultM, RdM, regwriteM); end
        checks++; if (dmem.dmem_req_o !== 1'b0 || stallM !== 1'b0) begin errors++; $display("FAIL next_req got req=%b stall=%b want 0,0", dmem.dmem_req_o, stallM); end
    endtask

    task automatic test_misalign();
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_W, 32'h102, 32'h0, 5'd8);
        dmem.dmem_ready_i = 1'b0;
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_H, 32'h101, 32'h0, 5'd9);
        @(negedge clk);
        checks++; if (misalignM !== 1'b1) begin errors++; $display("FAIL mis_lw got %b want 1", misalignM); end
        checks++; if (dmem.dmem_req_o !== 1'b0 || stallM !== 1'b0) begin errors++; $display("FAIL mis_lw_req got req=%b stall=%b want 0,0", dmem.dmem_req_o, stallM); end
        checks++; if (regwriteM !== 1'b0) begin errors++; $display("FAIL mis_lw_rw got %b want 0", regwriteM); end
        step();
        bubble_e();
        @(negedge clk);
        checks++; if (misalignM !== 1'b1 || dmem.dmem_req_o !== 1'b0) begin errors++; $display("FAIL mis_lh got mis=%b req=%b want 1,0", misalignM, dmem.dmem_req_o); end
        step();
        @(negedge clk);
        checks++; if (misalignM !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misalignM); end
    endtask

    task automatic test_flush();
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_W, 32'h300, 32'h0, 5'd10);
        flushE = 1'b1;
        step();
        flushE = 1'b0;
        bubble_e();
        @(negedge clk);
        checks++; if (regwriteM !== 1'b0 || RdM !== 5'd0 || dmem.dmem_req_o !== 1'b0) begin errors++; $display("FAIL flush got rw=%b rd=%0d req=%b want 0,0,0", regwriteM, RdM, dmem.dmem_req_o); end
    endtask

    task automatic test_reset_in_wait();
        step();
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_W, 32'h400, 32'h0, 5'd11);
        dmem.dmem_ready_i = 1'b0;
        step();
        bubble_e();
        step();
        @(negedge clk);
        checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL rw_pre_stall got %b want 1", stallM); end
        rst_n = 1'b0;
        #1;
        checks++; if (dmem.dmem_req_o !== 1'b0 || stallM !== 1'b0) begin errors++; $display("FAIL rw_async got req=%b stall=%b want 0,0", dmem.dmem_req_o, stallM); end
        step();
        rst_n = 1'b1;
        dmem.dmem_ready_i = 1'b1;
        dmem.dmem_rdata_i = 32'h12345678;
        @(negedge clk);
        checks++; if (dmem.dmem_req_o !== 1'b0 || regwriteM !== 1'b0 || ReadDataM !== 32'h0) begin errors++; $display("FAIL stale_ready got req=%b rw=%b data=%h want 0,0,0", dmem.dmem_req_o, regwriteM, ReadDataM); end
        step();
        dmem.dmem_ready_i = 1'b0;
        set_e(1'b1, 1'b1, 1'b0, 1'b1, F3_W, 32'h404, 32'h0, 5'd12);
        step();
        bubble_e();
        @(negedge clk);
        checks++; if (stallM !== 1'b1 || dmem.dmem_req_o !== 1'b1) begin errors++; $display("FAIL post_rst_lw got stall=%b req=%b want 1,1", stallM, dmem.dmem_req_o); end
        step();
        dmem.dmem_ready_i = 1'b1;
        step();
        dmem.dmem_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_back_to_back();
        test_store();
        test_wait();
        test_misalign();
        test_flush();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
